// File: rtl/zeroheti_pkg.sv
// -----------------------------------------------------------------------------
// zeroheti_pkg
// Shared constants and types for the zeroHETI interconnect blocks.
//   ArbMaxTransDefault : default outstanding-transaction limit of the OBI arbiter
//   ArbNumMgrDefault   : default manager count (SBA, instr, data)
//   arb_idx_t          : manager index at the default manager count; modules
//                        with a different count declare their own arb_idx_t
//   arb_state_e        : lock state of the OBI arbiter
//   arb_idx_width()    : index width for n managers, never below 1 bit
// -----------------------------------------------------------------------------
package zeroheti_pkg;

   localparam int ArbMaxTransDefault = 2;
   localparam int ArbNumMgrDefault   = 3;

   typedef logic [$clog2(ArbNumMgrDefault)-1:0] arb_idx_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int arb_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/zeroheti_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// zeroheti_arb_id_fifo
// In-order FIFO holding the manager index of every granted OBI transaction so
// that responses can be routed back to their issuer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : store data_i (accepted when not full, or full with a pop)
//   data_i       : manager index to store
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : Depth entries held
//   empty_o      : no entries held
//   data_o       : head entry
// -----------------------------------------------------------------------------
module zeroheti_arb_id_fifo #(
   parameter int Depth = 2,
   parameter int Width = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [Width-1:0] data_o
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   typedef logic [PtrW-1:0] ptr_t;

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   // When full, the slot being written is the one being popped this cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/zeroheti_obi_arbiter.sv
// -----------------------------------------------------------------------------
// zeroheti_obi_arbiter
// Round-robin arbiter sharing one OBI subordinate port between NumMgr managers
// (debug SBA, core instruction port, core data port). Up to MaxTrans granted
// transactions may be outstanding; an in-order ID FIFO routes responses back.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   mgr_*_i / mgr_*_o  : per-manager OBI request/grant/response channels
//                        (mgr_rdata_o is the subordinate data broadcast)
//   sbr_*_o / sbr_*_i  : OBI channel towards the shared subordinate
//   busy_o             : outstanding transactions or a held lock
//   unexp_rsp_o        : sticky, a response arrived with nothing outstanding
//
// Lock state machine:
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ARB_IDLE   | selection follows the round-robin search from rr_ptr
//   ARB_LOCKED | a request was presented but not granted; selection held on
//              | lock_idx so the presented request stays stable until gnt
// -----------------------------------------------------------------------------
module zeroheti_obi_arbiter
   import zeroheti_pkg::*;
#(
   parameter int NumMgr    = 3,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int MaxTrans  = ArbMaxTransDefault
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NumMgr-1:0]                    mgr_req_i,
   output logic [NumMgr-1:0]                    mgr_gnt_o,
   input  logic [NumMgr-1:0][AddrWidth-1:0]     mgr_addr_i,
   input  logic [NumMgr-1:0]                    mgr_we_i,
   input  logic [NumMgr-1:0][DataWidth/8-1:0]   mgr_be_i,
   input  logic [NumMgr-1:0][DataWidth-1:0]     mgr_wdata_i,
   output logic [NumMgr-1:0]                    mgr_rvalid_o,
   output logic [NumMgr-1:0][DataWidth-1:0]     mgr_rdata_o,
   output logic [NumMgr-1:0]                    mgr_err_o,
   output logic                                 sbr_req_o,
   input  logic                                 sbr_gnt_i,
   output logic [AddrWidth-1:0]                 sbr_addr_o,
   output logic                                 sbr_we_o,
   output logic [DataWidth/8-1:0]               sbr_be_o,
   output logic [DataWidth-1:0]                 sbr_wdata_o,
   input  logic                                 sbr_rvalid_i,
   input  logic [DataWidth-1:0]                 sbr_rdata_i,
   input  logic                                 sbr_err_i,
   output logic                                 busy_o,
   output logic                                 unexp_rsp_o
);

   localparam int IdxW = arb_idx_width(NumMgr);

   typedef logic [IdxW-1:0] arb_idx_t;

   arb_state_e state_q, state_d;
   arb_idx_t   lock_idx_q, lock_idx_d;
   arb_idx_t   rr_ptr_q, rr_ptr_d;
   logic       unexp_q, unexp_d;

   arb_idx_t   rr_sel, sel, fifo_head;
   logic       any_req, can_issue, sbr_req, handshake, pop;
   logic       fifo_full, fifo_empty;
   int         cand;

   // First requester at or after rr_ptr, cyclically. Scanning from the far end
   // lets the nearest hit overwrite the others, so no found-flag is needed.
   always_comb begin
      rr_sel = rr_ptr_q;
      cand   = 0;
      for (int i = NumMgr - 1; i >= 0; i--) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NumMgr) begin
            cand = cand - NumMgr;
         end
         if (mgr_req_i[arb_idx_t'(cand)]) begin
            rr_sel = arb_idx_t'(cand);
         end
      end
   end

   assign sel       = (state_q == ARB_LOCKED) ? lock_idx_q : rr_sel;
   assign any_req   = |mgr_req_i;
   // A full FIFO still admits a new push when the head retires this cycle.
   assign can_issue = ~fifo_full | sbr_rvalid_i;
   assign sbr_req   = ~rst_i & any_req & mgr_req_i[sel] & can_issue;
   assign handshake = sbr_req & sbr_gnt_i;
   assign pop       = ~rst_i & sbr_rvalid_i & ~fifo_empty;

   assign sbr_req_o   = sbr_req;
   assign sbr_addr_o  = rst_i ? '0   : mgr_addr_i[sel];
   assign sbr_we_o    = rst_i ? 1'b0 : mgr_we_i[sel];
   assign sbr_be_o    = rst_i ? '0   : mgr_be_i[sel];
   assign sbr_wdata_o = rst_i ? '0   : mgr_wdata_i[sel];
   assign mgr_rdata_o = rst_i ? '0   : {NumMgr{sbr_rdata_i}};

   always_comb begin
      mgr_gnt_o    = '0;
      mgr_rvalid_o = '0;
      mgr_err_o    = '0;
      if (handshake) begin
         mgr_gnt_o[sel] = 1'b1;
      end
      if (pop) begin
         mgr_rvalid_o[fifo_head] = 1'b1;
         mgr_err_o[fifo_head]    = sbr_err_i;
      end
   end

   assign busy_o      = ~rst_i & (~fifo_empty | (state_q == ARB_LOCKED));
   assign unexp_rsp_o = ~rst_i & unexp_q;

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      unexp_d    = unexp_q | (sbr_rvalid_i & fifo_empty);
      if (handshake) begin
         rr_ptr_d = (sel == arb_idx_t'(NumMgr - 1)) ? '0 : sel + arb_idx_t'(1);
      end
      case (state_q)
         ARB_IDLE: begin
            if (sbr_req & ~sbr_gnt_i) begin
               state_d    = ARB_LOCKED;
               lock_idx_d = sel;
            end
         end
         ARB_LOCKED: begin
            // A locked manager withdrawing its request also frees the port.
            if (handshake | ~mgr_req_i[lock_idx_q]) begin
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ARB_IDLE;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
         unexp_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         unexp_q    <= unexp_d;
      end
   end

   zeroheti_arb_id_fifo #(
      .Depth (MaxTrans),
      .Width (IdxW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (handshake),
      .data_i  (sel),
      .pop_i   (pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_o  (fifo_head)
   );

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
module tb_zeroheti_obi_arbiter;

   localparam int NUM  = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXT = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM-1:0]            req, we, gnt_o, rv_o, err_o;
   logic [NUM-1:0][AW-1:0]    addr;
   logic [NUM-1:0][DW/8-1:0]  be;
   logic [NUM-1:0][DW-1:0]    wdata, rdata_o;
   logic                      sreq, sgnt, swe, srvalid, serr, busy, unexp;
   logic [AW-1:0]             saddr;
   logic [DW/8-1:0]           sbe;
   logic [DW-1:0]             swdata, srdata;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   zeroheti_obi_arbiter #(
      .NumMgr    (NUM),
      .AddrWidth (AW),
      .DataWidth (DW),
      .MaxTrans  (MAXT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mgr_req_i    (req),
      .mgr_gnt_o    (gnt_o),
      .mgr_addr_i   (addr),
      .mgr_we_i     (we),
      .mgr_be_i     (be),
      .mgr_wdata_i  (wdata),
      .mgr_rvalid_o (rv_o),
      .mgr_rdata_o  (rdata_o),
      .mgr_err_o    (err_o),
      .sbr_req_o    (sreq),
      .sbr_gnt_i    (sgnt),
      .sbr_addr_o   (saddr),
      .sbr_we_o     (swe),
      .sbr_be_o     (sbe),
      .sbr_wdata_o  (swdata),
      .sbr_rvalid_i (srvalid),
      .sbr_rdata_i  (srdata),
      .sbr_err_i    (serr),
      .busy_o       (busy),
      .unexp_rsp_o  (unexp)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding transactions as a queue of issuer ids,
   // round-robin pointer as an integer, lock as an index (-1 = none).
   int m_rr    = 0;
   int m_lock  = -1;
   int m_q[$];
   bit m_unexp = 1'b0;
   int m_sel;
   bit m_sreq, m_pop;

   task automatic model_check();
      logic [NUM-1:0] e_gnt, e_rv, e_err;
      bit found;
      found = 1'b0;
      m_sel = m_rr;
      if (m_lock >= 0) m_sel = m_lock;
      else begin
         for (int k = 0; k < NUM; k++) begin
            if (!found && req[(m_rr + k) % NUM]) begin
               m_sel = (m_rr + k) % NUM;
               found = 1'b1;
            end
         end
      end
      m_sreq = !rst && (req != 0) && req[m_sel] && (m_q.size() < MAXT || srvalid);
      m_pop  = !rst && srvalid && (m_q.size() > 0);
      e_gnt  = (m_sreq && sgnt) ? NUM'(1 << m_sel) : '0;
      e_rv   = m_pop ? NUM'(1 << m_q[0]) : '0;
      e_err  = (m_pop && serr) ? e_rv : '0;
      chk("m_sbr_req", sreq, m_sreq);
      chk("m_gnt", gnt_o, e_gnt);
      chk("m_rvalid", rv_o, e_rv);
      chk("m_err", err_o, e_err);
      chk("m_busy", busy, !rst && (m_q.size() > 0 || m_lock >= 0));
      chk("m_unexp", unexp, !rst && m_unexp);
      chk("m_rdata", rdata_o, rst ? '0 : {NUM{srdata}});
      if (m_sreq) begin
         chk("m_addr", saddr, addr[m_sel]);
         chk("m_we", swe, we[m_sel]);
         chk("m_be", sbe, be[m_sel]);
         chk("m_wdata", swdata, wdata[m_sel]);
      end
      if (rst) chk("m_rst_addr", saddr, '0);
   endtask

   task automatic model_update();
      if (rst) begin
         m_rr    = 0;
         m_lock  = -1;
         m_q.delete();
         m_unexp = 1'b0;
      end else begin
         if (srvalid && m_q.size() == 0) m_unexp = 1'b1;
         if (m_pop) void'(m_q.pop_front());
         if (m_sreq && sgnt) begin
            m_q.push_back(m_sel);
            m_rr   = (m_sel + 1) % NUM;
            m_lock = -1;
         end else if (m_sreq) begin
            m_lock = m_sel;
         end else if (m_lock >= 0 && !req[m_lock]) begin
            m_lock = -1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] req;
      logic       gnt, rv, err;
      logic       e_sreq;
      logic [2:0] e_gnt, e_rv, e_err;
      int         e_sel;
      logic       e_busy;
   } vec_t;

   function automatic vec_t mk(logic [2:0] rq, logic g, logic r, logic e, logic sr,
                               logic [2:0] eg, logic [2:0] erv, logic [2:0] ee,
                               int es, logic eb);
      vec_t t;
      t.req = rq; t.gnt = g; t.rv = r; t.err = e; t.e_sreq = sr;
      t.e_gnt = eg; t.e_rv = erv; t.e_err = ee; t.e_sel = es; t.e_busy = eb;
      return t;
   endfunction

   function automatic logic [31:0] tbl_addr(int s);
      case (s)
         0:       return 32'h0000_1000;
         1:       return 32'h0000_2000;
         default: return 32'h0000_0200;
      endcase
   endfunction

   vec_t tbl[16];

   initial begin
      // fairness, error routing, lock, then drain
      tbl[0]  = mk(3'b111, 1, 0, 0, 1, 3'b001, 3'b000, 3'b000,  0, 0);
      tbl[1]  = mk(3'b111, 1, 1, 0, 1, 3'b010, 3'b001, 3'b000,  1, 1);
      tbl[2]  = mk(3'b111, 1, 1, 0, 1, 3'b100, 3'b010, 3'b000,  2, 1);
      tbl[3]  = mk(3'b111, 1, 1, 0, 1, 3'b001, 3'b100, 3'b000,  0, 1);
      tbl[4]  = mk(3'b111, 1, 1, 0, 1, 3'b010, 3'b001, 3'b000,  1, 1);
      tbl[5]  = mk(3'b111, 1, 1, 0, 1, 3'b100, 3'b010, 3'b000,  2, 1);
      tbl[6]  = mk(3'b000, 1, 1, 1, 0, 3'b000, 3'b100, 3'b100, -1, 1);
      tbl[7]  = mk(3'b010, 1, 0, 0, 1, 3'b010, 3'b000, 3'b000,  1, 0);
      tbl[8]  = mk(3'b000, 0, 1, 1, 0, 3'b000, 3'b010, 3'b010, -1, 1);
      tbl[9]  = mk(3'b100, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000,  2, 0);
      tbl[10] = mk(3'b101, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000,  2, 1);
      tbl[11] = mk(3'b101, 0, 0, 0, 1, 3'b000, 3'b000, 3'b000,  2, 1);
      tbl[12] = mk(3'b101, 1, 0, 0, 1, 3'b100, 3'b000, 3'b000,  2, 1);
      tbl[13] = mk(3'b001, 1, 1, 0, 1, 3'b001, 3'b100, 3'b000,  0, 1);
      tbl[14] = mk(3'b000, 0, 1, 0, 0, 3'b000, 3'b001, 3'b000, -1, 1);
      tbl[15] = mk(3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, -1, 0);

      rst = 1'b1; req = '1; sgnt = 1'b1; srvalid = 1'b1; serr = 1'b1;
      srdata = 32'h1234_5678;
      for (int k = 0; k < NUM; k++) begin
         addr[k]  = tbl_addr(k);
         we[k]    = (k == 1);
         be[k]    = 4'(1 << k);
         wdata[k] = 32'hD0 + 32'(k);
      end

      // outputs forced low while reset is asserted
      cycle();
      chk("rst_sbr_req", sreq, 1'b0);
      chk("rst_gnt", gnt_o, 3'b000);
      chk("rst_rvalid", rv_o, 3'b000);
      chk("rst_addr", saddr, 32'h0);
      advance();
      rst = 1'b0; req = '0; sgnt = 1'b0; srvalid = 1'b0; serr = 1'b0;
      cycle();
      chk("rst_busy", busy, 1'b0);
      chk("rst_unexp", unexp, 1'b0);
      advance();

      for (int i = 0; i < 16; i++) begin
         req = tbl[i].req; sgnt = tbl[i].gnt; srvalid = tbl[i].rv; serr = tbl[i].err;
         srdata = 32'hC000_0000 + 32'(i);
         cycle();
         chk($sformatf("tbl%0d_sbr_req", i), sreq, tbl[i].e_sreq);
         chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].e_gnt);
         chk($sformatf("tbl%0d_rvalid", i), rv_o, tbl[i].e_rv);
         chk($sformatf("tbl%0d_err", i), err_o, tbl[i].e_err);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         if (tbl[i].e_sel >= 0) begin
            chk($sformatf("tbl%0d_addr", i), saddr, tbl_addr(tbl[i].e_sel));
            chk($sformatf("tbl%0d_we", i), swe, tbl[i].e_sel == 1);
         end
         advance();
      end

      // single requester, back-to-back reads with 1-cycle responses
      we = '0;
      for (int k = 0; k < 5; k++) begin
         req     = (k < 4) ? 3'b010 : 3'b000;
         addr[1] = 32'h100 + 32'(4 * k);
         sgnt    = 1'b1;
         srvalid = (k > 0);
         serr    = 1'b0;
         srdata  = 32'hA0 + 32'(k) - 32'd1;
         cycle();
         if (k < 4) begin
            chk("sr_gnt", gnt_o, 3'b010);
            chk("sr_addr", saddr, 32'h100 + 32'(4 * k));
         end
         if (k > 0) begin
            chk("sr_rvalid", rv_o, 3'b010);
            chk("sr_rdata", rdata_o[1], 32'hA0 + 32'(k) - 32'd1);
         end
         advance();
      end

      // FIFO full: third request waits, then issues together with the first response
      req = 3'b001; sgnt = 1'b1; srvalid = 1'b0;
      cycle(); chk("ff_gnt0", gnt_o, 3'b001); advance();
      cycle(); chk("ff_gnt1", gnt_o, 3'b001); advance();
      cycle(); chk("ff_stall_req", sreq, 1'b0); chk("ff_stall_gnt", gnt_o, 3'b000); advance();
      srvalid = 1'b1;
      cycle();
      chk("ff_pop_req", sreq, 1'b1);
      chk("ff_pop_gnt", gnt_o, 3'b001);
      chk("ff_pop_rvalid", rv_o, 3'b001);
      advance();
      req = 3'b000;
      cycle(); chk("ff_drain0", rv_o, 3'b001); advance();
      cycle(); chk("ff_drain1", rv_o, 3'b001); advance();
      srvalid = 1'b0;
      cycle(); chk("ff_idle_busy", busy, 1'b0); advance();

      // reset with transactions outstanding, then a stray response
      req = 3'b100; sgnt = 1'b1;
      cycle(); chk("ro_gnt0", gnt_o, 3'b100); advance();
      cycle(); chk("ro_gnt1", gnt_o, 3'b100); chk("ro_busy", busy, 1'b1); advance();
      rst = 1'b1; srvalid = 1'b1;
      cycle(); chk("ro_rst_rvalid", rv_o, 3'b000); chk("ro_rst_req", sreq, 1'b0); advance();
      rst = 1'b0; req = 3'b000; srvalid = 1'b0;
      cycle(); chk("ro_busy_after", busy, 1'b0); chk("ro_unexp0", unexp, 1'b0); advance();
      srvalid = 1'b1;
      cycle(); chk("ro_stray_rvalid", rv_o, 3'b000); advance();
      srvalid = 1'b0;
      cycle(); chk("ro_unexp1", unexp, 1'b1); advance();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < NUM; k++) begin
            req[k]   = ($urandom_range(0, 99) < 55);
            addr[k]  = $urandom;
            we[k]    = 1'($urandom);
            be[k]    = 4'($urandom);
            wdata[k] = $urandom;
         end
         if (m_lock >= 0 && $urandom_range(0, 99) < 90) req[m_lock] = 1'b1;
         sgnt    = ($urandom_range(0, 99) < 60);
         srvalid = (m_q.size() > 0) ? ($urandom_range(0, 99) < 50)
                                    : ($urandom_range(0, 199) == 0);
         serr    = 1'($urandom);
         srdata  = $urandom;
         cycle();
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/zeroheti_obi_arbiter.md
Name: zeroheti_obi_arbiter

Overview:
- Shares one OBI subordinate port (for example a single-port SRAM bank or the APB bridge input) between NumMgr OBI managers.
- Managers are the debug SBA, the instruction port and the data port of the zeroHETI core.
- Arbitration is round-robin. A selection is locked from the first presented request until that request is granted.
- Up to MaxTrans granted transactions can be outstanding. An in-order ID FIFO routes each response back to the manager that issued it.
- Sits between the xbar manager side and one subordinate, so several masters can reach one memory without a full crossbar.

Parameters:
- NumMgr, 3: number of requesting managers; index 0 is the lowest index.
- AddrWidth, 32: OBI address width.
- DataWidth, 32: OBI data width; byte-enable width is DataWidth/8.
- MaxTrans, 2: maximum outstanding granted-but-unresponded transactions; must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mgr_req_i  in  NumMgr  per-manager request.
- mgr_gnt_o  out  NumMgr  per-manager grant.
- mgr_addr_i  in  NumMgr×AddrWidth  per-manager address.
- mgr_we_i  in  NumMgr  per-manager write enable.
- mgr_be_i  in  NumMgr×DataWidth/8  per-manager byte enables.
- mgr_wdata_i  in  NumMgr×DataWidth  per-manager write data.
- mgr_rvalid_o  out  NumMgr  per-manager response valid.
- mgr_rdata_o  out  NumMgr×DataWidth  response data, broadcast to all managers.
- mgr_err_o  out  NumMgr  per-manager response error.
- sbr_req_o  out  1  request to the subordinate.
- sbr_gnt_i  in  1  grant from the subordinate.
- sbr_addr_o  out  AddrWidth  address to the subordinate.
- sbr_we_o  out  1  write enable to the subordinate.
- sbr_be_o  out  DataWidth/8  byte enables to the subordinate.
- sbr_wdata_o  out  DataWidth  write data to the subordinate.
- sbr_rvalid_i  in  1  response valid from the subordinate.
- sbr_rdata_i  in  DataWidth  response data from the subordinate.
- sbr_err_i  in  1  response error from the subordinate.
- busy_o  out  1  high when the ID FIFO is non-empty or a lock is held.
- unexp_rsp_o  out  1  sticky flag: an rvalid arrived with the FIFO empty.

Behaviour:
- Reset (rst_i high at a clock edge):
  - rr_ptr=0, lock cleared, FIFO emptied, unexp_rsp_o=0.
  - All outputs driven 0 while rst_i is high.
  - In-flight responses are discarded: an rvalid in the same cycle as reset is dropped silently.
- Selection:
  - If locked, sel = lock_idx.
  - Otherwise sel = the first requesting index at or after rr_ptr, searching cyclically modulo NumMgr.
- can_issue = FIFO not full, or FIFO full AND a pop happens this cycle (sbr_rvalid_i). The same-cycle push/pop at full is allowed.
- Request path, combinational, zero-cycle latency:
  - sbr_req_o = mgr_req_i[sel] & any request & can_issue.
  - addr, we, be and wdata are muxed from sel.
  - mgr_gnt_o[sel] = sbr_req_o & sbr_gnt_i; all other grant bits are 0.
- Lock state machine (states IDLE and LOCKED):
  - IDLE→LOCKED when sbr_req_o=1 and sbr_gnt_i=0; lock_idx=sel. This keeps the OBI stable-request rule.
  - LOCKED→IDLE on a handshake (sbr_req_o & sbr_gnt_i).
  - A locked manager dropping req (protocol violation) also releases the lock. No grant is issued in that case.
- Handshake (sbr_req_o & sbr_gnt_i):
  - Push sel into the FIFO.
  - rr_ptr = (sel+1) mod NumMgr, wrapping from NumMgr-1 to 0.
- Response path:
  - On sbr_rvalid_i with the FIFO non-empty, pop the head h.
  - mgr_rvalid_o[h]=1 and mgr_err_o[h]=sbr_err_i in the same cycle; all other rvalid and err bits are 0.
  - mgr_rdata_o carries sbr_rdata_i to all managers.
- Unexpected response: sbr_rvalid_i with the FIFO empty sets unexp_rsp_o, which holds until reset. The response is dropped.
- FIFO:
  - Depth MaxTrans; entry width $clog2(NumMgr), minimum 1 bit.
  - Responses are strictly in order; the subordinate is required to respond in order.
- Boundary conditions:
  - A response arriving in the same cycle as the grant is not possible. Minimum response latency is 1 cycle after gnt, per OBI.
  - With the FIFO full and no pop, sbr_req_o stays low and requesters wait. An already-held lock stays held.
  - Single requester: that manager is served back-to-back with one transaction per cycle, subject to MaxTrans.

Decomposition:
- Shared package zeroheti_pkg gains:
  - constant ArbMaxTransDefault=2;
  - typedef arb_idx_t, sized as logic[$clog2(NumMgr)-1:0] and instantiated per use.
- Sub-module zeroheti_arb_id_fifo:
  - parameterised depth and width;
  - push/pop inputs, full/empty flags, head output;
  - supports simultaneous push and pop when full.
- The arbiter core and lock FSM stay in the top module.

Test Plan:
- Single requester, 1-cycle subordinate with gnt always 1, MaxTrans=2: mgr1 issues 4 reads to 0x100..0x10C → 4 gnts on consecutive cycles, 4 rvalids one cycle later, each routed to mgr1 only, rdata in order.
- Fairness: all 3 managers request continuously → grant order 0,1,2,0,1,2. rr_ptr wraps from 2 to 0.
- Lock:
  - mgr2 requests addr 0x200; the subordinate withholds gnt for 3 cycles while mgr0 also requests.
  - sbr_addr_o stays 0x200 and sel stays 2 until gnt.
  - mgr0 is granted on the next cycle.
- FIFO full:
  - MaxTrans=2, responses stalled → the third request sees sbr_req_o=0.
  - When the first rvalid arrives, the third request is granted in the same cycle.
- Error routing: mgr1 write gets sbr_err_i=1 → mgr_err_o=3'b010 with mgr_rvalid_o=3'b010.
- Reset and unexpected response:
  - Assert rst_i with 2 outstanding transactions → busy_o=0 the next cycle.
  - A later rvalid sets unexp_rsp_o=1 and no mgr_rvalid_o bit goes high.
